dkong_input_ctrl: RTL and testbench
===================================

// Module: dkong_input_ctrl
// PURPOSE
//  Input front end feeding the dkong_top control pins. Decodes PS/2 key events and merges both
//  joysticks. Applies 90-degree remap when the screen is horizontal.
//  Shapes the coin request into a fixed-width, one-shot arcade coin pulse.
//  All outputs are active-low and drive I_U1..I_C1 of dkong_top directly.
// PARAMETERS
//  COIN_CYCLES  2457600  coin pulse width in clock cycles (100 ms at 24.576 MHz)
//  CNT_W        22       coin counter width; must satisfy 2**CNT_W > COIN_CYCLES
// PORTS
//  I_CLK_24576M  in   1   system clock
//  I_RESETn      in   1   async reset, active-low
//  I_PS2_KEY     in   11  [10]=event toggle, [9]=pressed, [8:0]=scancode (bit8 = E0 extended)
//  I_JOY0        in   16  joystick 0: [0]R [1]L [2]D [3]U [4]jump [5]start1 [6]start2 [7]coin
//  I_JOY1        in   16  joystick 1, same map
//  I_ROTATE      in   1   1 = horizontal orientation, so apply direction remap
//  O_U1,O_D1,O_L1,O_R1,O_J1  out 1 each  player-1 controls, active-low
//  O_U2,O_D2,O_L2,O_R2,O_J2  out 1 each  player-2 controls, active-low
//  O_S1,O_S2     out  1   start buttons, active-low
//  O_C1          out  1   coin, active-low, shaped pulse
// BEHAVIOUR
//  - Reset: all key latches = 0, coin FSM = IDLE, counter = 0, every output = 1 (released).
//  - Key event: the register old_tog samples I_PS2_KEY[10] each cycle.
//    When the bit differs from old_tog, the matching key latch is loaded with I_PS2_KEY[9].
//  - Arrow keys match on scancode[7:0] only: 75 U, 72 D, 6B L, 74 R.
//  - All other keys require scancode[8]=0. P1 jump: 029 or 014. Start1: 005 or 016. Start2: 006 or 01E.
//    Coin: 02E or 036. P2 controls: 02D U, 02B D, 023 L, 034 R, 01C jump.
//  - Unknown codes are ignored. Only one latch changes per event.
//  - Joysticks: joy = I_JOY0 | I_JOY1. The OR-ed joy bits feed both P1 and P2 directions and jump.
//  - Remap when I_ROTATE=1: U<-L, D<-R, L<-D, R<-U, applied to key and joy terms alike.
//    Remap is combinational from the latches and is applied before registering.
//  - Control outputs are registered, 1-cycle latency from latch or joy change, inverted.
//  - Coin request creq = coin keys | joy[7] (plus starts, see CONFIGURATION).
//  - Coin FSM (3 states):
//      IDLE: on creq=1, go to PULSE with cnt=0.
//      PULSE: O_C1=0; cnt++. When cnt==COIN_CYCLES-1, go to WAIT_REL.
//        O_C1 is low for exactly COIN_CYCLES cycles.
//      WAIT_REL: O_C1=1. When creq=0, go to IDLE.
//  - Coin boundaries: creq held forever yields exactly one pulse.
//    A release and re-press during PULSE is ignored; the FSM still waits for release in WAIT_REL.
//    A release during PULSE means WAIT_REL exits on the next cycle.
//    Reset during PULSE aborts the pulse immediately, with O_C1=1 asynchronously.
//  - Simultaneous press of a key and the same joy bit: plain OR, no glitch.
// CONFIGURATION
//  DKONG_AUTOCOIN_EN defined: creq also includes start1 | start2 (key or joy).
//    One start press inserts a coin and asserts start.
//  Undefined: start buttons never generate coin; creq = coin keys | joy[7] only.
// STRUCTURE
//  - dkong_input_pkg holds the scancode localparams (SC_UP, SC_DOWN, SC_JUMP_A, ...).
//    It also holds the joy bit indices and typedef enum logic [1:0] {IDLE, PULSE, WAIT_REL} coin_st_t.
//  - Sub-module dkong_coin_pulse (params COIN_CYCLES, CNT_W; ports clk, rst_n, req, o_coin_n).
//    It contains the coin FSM and counter. The top does decode, merge, remap and output registers.
// TESTING (bench uses COIN_CYCLES=16, CNT_W=5)
//  1. Reset: hold I_RESETn=0 -> all 13 outputs =1. Release, no stimulus -> outputs stay 1.
//  2. Event {tog^1,1,9'h175} -> O_U1=0 two cycles later. Event {tog^1,0,9'h175} -> O_U1=1.
//     Same events without a toggle change -> no output change.
//  3. I_ROTATE=1 and key 06B (left) pressed -> O_U1=0, O_L1=1.
//     I_ROTATE=0 with the same press -> O_L1=0.
//  4. joy0[7]=1 held 100 cycles -> O_C1 low exactly 16 cycles, then 1. Release and re-press -> second 16-cycle pulse.
//  5. Reset asserted mid-pulse at cnt=5 -> O_C1=1 same cycle. After release, FSM in IDLE and creq=1 -> new full pulse.
//  6. Key 016 pressed -> O_S1=0. O_C1 pulses with DKONG_AUTOCOIN_EN; O_C1 stays 1 without it.

Source files
------------

// File: rtl/dkong_input_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dkong_input_pkg
// Purpose : Shared constants and types for the dkong input front end:
//           PS/2 scancodes, joystick bit indices, key-latch indices,
//           coin FSM state type, key decoder and rotation remap helpers.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package dkong_input_pkg;

   // Arrow keys are matched on the low byte only, so the E0-prefixed and
   // keypad variants both work.
   localparam logic [7:0] SC_UP       = 8'h75;
   localparam logic [7:0] SC_DOWN     = 8'h72;
   localparam logic [7:0] SC_LEFT     = 8'h6B;
   localparam logic [7:0] SC_RIGHT    = 8'h74;

   // All remaining keys must be non-extended (bit 8 clear).
   localparam logic [8:0] SC_JUMP_A   = 9'h029;
   localparam logic [8:0] SC_JUMP_B   = 9'h014;
   localparam logic [8:0] SC_START1_A = 9'h005;
   localparam logic [8:0] SC_START1_B = 9'h016;
   localparam logic [8:0] SC_START2_A = 9'h006;
   localparam logic [8:0] SC_START2_B = 9'h01E;
   localparam logic [8:0] SC_COIN_A   = 9'h02E;
   localparam logic [8:0] SC_COIN_B   = 9'h036;
   localparam logic [8:0] SC_P2_UP    = 9'h02D;
   localparam logic [8:0] SC_P2_DOWN  = 9'h02B;
   localparam logic [8:0] SC_P2_LEFT  = 9'h023;
   localparam logic [8:0] SC_P2_RIGHT = 9'h034;
   localparam logic [8:0] SC_P2_JUMP  = 9'h01C;

   // Joystick word bit positions
   localparam int JOY_R      = 0;
   localparam int JOY_L      = 1;
   localparam int JOY_D      = 2;
   localparam int JOY_U      = 3;
   localparam int JOY_JUMP   = 4;
   localparam int JOY_START1 = 5;
   localparam int JOY_START2 = 6;
   localparam int JOY_COIN   = 7;

   // Key latch indices (one latch per game function)
   localparam int KEY_U1   = 0;
   localparam int KEY_D1   = 1;
   localparam int KEY_L1   = 2;
   localparam int KEY_R1   = 3;
   localparam int KEY_J1   = 4;
   localparam int KEY_U2   = 5;
   localparam int KEY_D2   = 6;
   localparam int KEY_L2   = 7;
   localparam int KEY_R2   = 8;
   localparam int KEY_J2   = 9;
   localparam int KEY_S1   = 10;
   localparam int KEY_S2   = 11;
   localparam int KEY_COIN = 12;
   localparam int KEY_NUM  = 13;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULSE    = 2'd1,
      WAIT_REL = 2'd2
   } coin_st_t;

   // One-hot (or zero) latch select for a scancode. The priority chain
   // guarantees at most one latch is touched per event.
   function automatic logic [KEY_NUM-1:0] key_decode(input logic [8:0] sc);
      logic [KEY_NUM-1:0] m;
      m = '0;
      if      (sc[7:0] == SC_UP)                          m[KEY_U1]   = 1'b1;
      else if (sc[7:0] == SC_DOWN)                        m[KEY_D1]   = 1'b1;
      else if (sc[7:0] == SC_LEFT)                        m[KEY_L1]   = 1'b1;
      else if (sc[7:0] == SC_RIGHT)                       m[KEY_R1]   = 1'b1;
      else if (sc == SC_JUMP_A   || sc == SC_JUMP_B)      m[KEY_J1]   = 1'b1;
      else if (sc == SC_START1_A || sc == SC_START1_B)    m[KEY_S1]   = 1'b1;
      else if (sc == SC_START2_A || sc == SC_START2_B)    m[KEY_S2]   = 1'b1;
      else if (sc == SC_COIN_A   || sc == SC_COIN_B)      m[KEY_COIN] = 1'b1;
      else if (sc == SC_P2_UP)                            m[KEY_U2]   = 1'b1;
      else if (sc == SC_P2_DOWN)                          m[KEY_D2]   = 1'b1;
      else if (sc == SC_P2_LEFT)                          m[KEY_L2]   = 1'b1;
      else if (sc == SC_P2_RIGHT)                         m[KEY_R2]   = 1'b1;
      else if (sc == SC_P2_JUMP)                          m[KEY_J2]   = 1'b1;
      return m;
   endfunction

   // Direction remap for a horizontally mounted screen.
   // Returns {up, down, left, right}: U<-L, D<-R, L<-D, R<-U when rotated.
   function automatic logic [3:0] dir_remap(input logic rot, input logic u,
                                            input logic d, input logic l,
                                            input logic r);
      return rot ? {l, r, d, u} : {u, d, l, r};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dkong_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : dkong_input_ctrl_if
// Purpose : Bundles the input-side sources (PS/2 key events, joysticks,
//           rotate strap) and the active-low control pins toward dkong_top.
// Ports   : I_PS2_KEY[10:0], I_JOY0[15:0], I_JOY1[15:0], I_ROTATE  (to ctrl)
//           O_U1/D1/L1/R1/J1, O_U2/D2/L2/R2/J2, O_S1, O_S2, O_C1 (from ctrl)
//           master modport = stimulus side, slave modport = input controller
// Revision: 1.0 - initial release
// ============================================================================
interface dkong_input_ctrl_if;
   logic [10:0] I_PS2_KEY;
   logic [15:0] I_JOY0;
   logic [15:0] I_JOY1;
   logic        I_ROTATE;
   logic        O_U1, O_D1, O_L1, O_R1, O_J1;
   logic        O_U2, O_D2, O_L2, O_R2, O_J2;
   logic        O_S1, O_S2, O_C1;

   modport master (
      output I_PS2_KEY, I_JOY0, I_JOY1, I_ROTATE,
      input  O_U1, O_D1, O_L1, O_R1, O_J1,
      input  O_U2, O_D2, O_L2, O_R2, O_J2,
      input  O_S1, O_S2, O_C1
   );

   modport slave (
      input  I_PS2_KEY, I_JOY0, I_JOY1, I_ROTATE,
      output O_U1, O_D1, O_L1, O_R1, O_J1,
      output O_U2, O_D2, O_L2, O_R2, O_J2,
      output O_S1, O_S2, O_C1
   );
endinterface
`default_nettype wire

// File: rtl/dkong_coin_pulse.sv
`default_nettype none
// ============================================================================
// Module  : dkong_coin_pulse
// Purpose : Turns a level coin request into one fixed-width active-low pulse
//           of COIN_CYCLES clocks, then waits for the request to drop before
//           it can fire again.
// Params  : COIN_CYCLES - pulse width in clocks
//           CNT_W       - counter width, 2**CNT_W > COIN_CYCLES
// Ports   : clk      in  clock
//           rst_n    in  async reset, active-low
//           req      in  coin request level
//           o_coin_n out coin pulse, active-low
// Revision: 1.0 - initial release
// ============================================================================
module dkong_coin_pulse
   import dkong_input_pkg::*;
#(
   parameter int COIN_CYCLES = 2457600,
   parameter int CNT_W       = 22
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic req,
   output logic      o_coin_n
);

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(COIN_CYCLES - 1);

   coin_st_t         r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Output is decoded from the state register alone, so reset releases
   // the coin line asynchronously.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_coin_n    = 1'b1;
      case (r_state)
         IDLE: begin
            if (req) begin
               w_state_nxt = PULSE;
               w_cnt_nxt   = '0;
            end
         end
         PULSE: begin
            o_coin_n = 1'b0;
            if (r_cnt == c_LAST) begin
               w_state_nxt = WAIT_REL;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         WAIT_REL: begin
            if (!req) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dkong_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dkong_input_ctrl
// Purpose : Input front end for dkong_top. Latches PS/2 key state, merges
//           both joysticks, remaps directions for a horizontal screen and
//           registers the active-low control pins; coin is shaped by
//           dkong_coin_pulse.
// Config  : DKONG_AUTOCOIN_EN - when defined, start buttons also request a
//           coin (one start press inserts a coin and starts).
// Params  : COIN_CYCLES, CNT_W - forwarded to dkong_coin_pulse
// Ports   : I_CLK_24576M in  system clock
//           I_RESETn     in  async reset, active-low
//           bus          slave modport of dkong_input_ctrl_if
// Revision: 1.0 - initial release
// ============================================================================
module dkong_input_ctrl
   import dkong_input_pkg::*;
#(
   parameter int COIN_CYCLES = 2457600,
   parameter int CNT_W       = 22
) (
   input  wire logic          I_CLK_24576M,
   input  wire logic          I_RESETn,
   dkong_input_ctrl_if.slave  bus
);

   logic               r_old_tog;
   logic [KEY_NUM-1:0] r_keys;
   logic [KEY_NUM-1:0] w_key_mask;
   logic               w_key_ev;
   logic [15:0]        w_joy;
   logic [3:0]         w_dir1, w_dir2;   // {up, down, left, right}
   logic               w_creq;
   logic               w_coin_n;
   logic               w_unused;

   logic r_u1_n, r_d1_n, r_l1_n, r_r1_n, r_j1_n;
   logic r_u2_n, r_d2_n, r_l2_n, r_r2_n, r_j2_n;
   logic r_s1_n, r_s2_n;

   // A key event is any change of the toggle bit since the last cycle.
   assign w_key_ev   = bus.I_PS2_KEY[10] ^ r_old_tog;
   assign w_key_mask = key_decode(bus.I_PS2_KEY[8:0]);

   always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
      if (!I_RESETn) begin
         r_old_tog <= 1'b0;
         r_keys    <= '0;
      end else begin
         r_old_tog <= bus.I_PS2_KEY[10];
         if (w_key_ev) begin
            r_keys <= (r_keys & ~w_key_mask) |
                      (w_key_mask & {KEY_NUM{bus.I_PS2_KEY[9]}});
         end
      end
   end

   assign w_joy    = bus.I_JOY0 | bus.I_JOY1;
   assign w_unused = ^w_joy[15:8];

   // Joystick directions drive both players; keys are per player.
   assign w_dir1 = dir_remap(bus.I_ROTATE,
                             r_keys[KEY_U1] | w_joy[JOY_U],
                             r_keys[KEY_D1] | w_joy[JOY_D],
                             r_keys[KEY_L1] | w_joy[JOY_L],
                             r_keys[KEY_R1] | w_joy[JOY_R]);
   assign w_dir2 = dir_remap(bus.I_ROTATE,
                             r_keys[KEY_U2] | w_joy[JOY_U],
                             r_keys[KEY_D2] | w_joy[JOY_D],
                             r_keys[KEY_L2] | w_joy[JOY_L],
                             r_keys[KEY_R2] | w_joy[JOY_R]);

   always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
      if (!I_RESETn) begin
         r_u1_n <= 1'b1;  r_d1_n <= 1'b1;  r_l1_n <= 1'b1;  r_r1_n <= 1'b1;
         r_j1_n <= 1'b1;
         r_u2_n <= 1'b1;  r_d2_n <= 1'b1;  r_l2_n <= 1'b1;  r_r2_n <= 1'b1;
         r_j2_n <= 1'b1;
         r_s1_n <= 1'b1;  r_s2_n <= 1'b1;
      end else begin
         r_u1_n <= ~w_dir1[3];
         r_d1_n <= ~w_dir1[2];
         r_l1_n <= ~w_dir1[1];
         r_r1_n <= ~w_dir1[0];
         r_j1_n <= ~(r_keys[KEY_J1] | w_joy[JOY_JUMP]);
         r_u2_n <= ~w_dir2[3];
         r_d2_n <= ~w_dir2[2];
         r_l2_n <= ~w_dir2[1];
         r_r2_n <= ~w_dir2[0];
         r_j2_n <= ~(r_keys[KEY_J2] | w_joy[JOY_JUMP]);
         r_s1_n <= ~(r_keys[KEY_S1] | w_joy[JOY_START1]);
         r_s2_n <= ~(r_keys[KEY_S2] | w_joy[JOY_START2]);
      end
   end

`ifdef DKONG_AUTOCOIN_EN
   assign w_creq = r_keys[KEY_COIN] | w_joy[JOY_COIN] |
                   r_keys[KEY_S1]   | w_joy[JOY_START1] |
                   r_keys[KEY_S2]   | w_joy[JOY_START2];
`else
   assign w_creq = r_keys[KEY_COIN] | w_joy[JOY_COIN];
`endif

   dkong_coin_pulse #(
      .COIN_CYCLES (COIN_CYCLES),
      .CNT_W       (CNT_W)
   ) u_coin_pulse (
      .clk      (I_CLK_24576M),
      .rst_n    (I_RESETn),
      .req      (w_creq),
      .o_coin_n (w_coin_n)
   );

   assign bus.O_U1 = r_u1_n;
   assign bus.O_D1 = r_d1_n;
   assign bus.O_L1 = r_l1_n;
   assign bus.O_R1 = r_r1_n;
   assign bus.O_J1 = r_j1_n;
   assign bus.O_U2 = r_u2_n;
   assign bus.O_D2 = r_d2_n;
   assign bus.O_L2 = r_l2_n;
   assign bus.O_R2 = r_r2_n;
   assign bus.O_J2 = r_j2_n;
   assign bus.O_S1 = r_s1_n;
   assign bus.O_S2 = r_s2_n;
   assign bus.O_C1 = w_coin_n;

endmodule
`default_nettype wire

// File: tb/tb_dkong_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dkong_input_ctrl
// Purpose : Directed self-checking bench for dkong_input_ctrl
//           (COIN_CYCLES=16, CNT_W=5).
// Output vector order used below:
//   [12]U1 [11]D1 [10]L1 [9]R1 [8]J1 [7]U2 [6]D2 [5]L2 [4]R2 [3]J2
//   [2]S1  [1]S2  [0]C1
// Revision: 1.0 - initial release
// ============================================================================
module tb_dkong_input_ctrl;

   localparam int COIN_CYCLES = 16;
   localparam int CNT_W       = 5;

   logic clk = 1'b0;
   logic rst_n;
   logic tog = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   dkong_input_ctrl_if bus ();

   dkong_input_ctrl #(
      .COIN_CYCLES (COIN_CYCLES),
      .CNT_W       (CNT_W)
   ) dut (
      .I_CLK_24576M (clk),
      .I_RESETn     (rst_n),
      .bus          (bus)
   );

   function automatic logic [12:0] outs();
      return {bus.O_U1, bus.O_D1, bus.O_L1, bus.O_R1, bus.O_J1,
              bus.O_U2, bus.O_D2, bus.O_L2, bus.O_R2, bus.O_J2,
              bus.O_S1, bus.O_S2, bus.O_C1};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic pressed, input logic [8:0] sc);
      tog = ~tog;
      bus.I_PS2_KEY = {tog, pressed, sc};
   endtask

   // Counts low cycles and falling edges of O_C1 over n clocks.
   task automatic measure_coin(input int n, output int lows, output int falls);
      logic prev;
      lows  = 0;
      falls = 0;
      prev  = bus.O_C1;
      for (int i = 0; i < n; i++) begin
         step(1);
         if (bus.O_C1 === 1'b0) begin
            lows++;
            if (prev === 1'b1) falls++;
         end
         prev = bus.O_C1;
      end
   endtask

   task automatic test_reset();
      logic [12:0] o;
      rst_n = 1'b0;
      tog = 1'b0;
      bus.I_PS2_KEY = '0;
      bus.I_JOY0 = '0;
      bus.I_JOY1 = '0;
      bus.I_ROTATE = 1'b0;
      step(3);
      o = outs();
      checks++;
      if (o !== 13'h1FFF) begin
         failures++;
         $display("FAIL reset_hold: got %h expected %h", o, 13'h1FFF);
      end
      rst_n = 1'b1;
      step(5);
      o = outs();
      checks++;
      if (o !== 13'h1FFF) begin
         failures++;
         $display("FAIL reset_idle: got %h expected %h", o, 13'h1FFF);
      end
   endtask

   task automatic test_key_event();
      logic [12:0] o;
      send_key(1'b1, 9'h175);
      step(1);
      o = outs();
      checks++;
      if (o !== 13'h1FFF) begin
         failures++;
         $display("FAIL key_latency1: got %h expected %h", o, 13'h1FFF);
      end
      step(1);
      o = outs();
      checks++;
      if (o !== 13'h0FFF) begin
         failures++;
         $display("FAIL key_up_press: got %h expected %h", o, 13'h0FFF);
      end
      bus.I_PS2_KEY[9] = 1'b0;       // no toggle change: must be ignored
      step(3);
      o = outs();
      checks++;
      if (o !== 13'h0FFF) begin
         failures++;
         $display("FAIL key_no_toggle_rel: got %h expected %h", o, 13'h0FFF);
      end
      send_key(1'b0, 9'h175);
      step(2);
      o = outs();
      checks++;
      if (o !== 13'h1FFF) begin
         failures++;
         $display("FAIL key_up_release: got %h expected %h", o, 13'h1FFF);
      end
      bus.I_PS2_KEY[9] = 1'b1;
      step(3);
      o = outs();
      checks++;
      if (o !== 13'h1FFF) begin
         failures++;
         $display("FAIL key_no_toggle_press: got %h expected %h", o, 13'h1FFF);
      end
      send_key(1'b1, 9'h014);
      step(2);
      o = outs();
      checks++;
      if (o !== 13'h1EFF) begin
         failures++;
         $display("FAIL key_jump1: got %h expected %h", o, 13'h1EFF);
      end
      send_key(1'b0, 9'h014);
      step(2);
      send_key(1'b1, 9'h114);        // extended variant of a non-arrow key
      step(2);
      o = outs();
      checks++;
      if (o !== 13'h1FFF) begin
         failures++;
         $display("FAIL key_ext_ignored: got %h expected %h", o, 13'h1FFF);
      end
      send_key(1'b1, 9'h02D);
      step(2);
      o = outs();
      checks++;
      if (o !== 13'h1F7F) begin
         failures++;
         $display("FAIL key_p2_up: got %h expected %h", o, 13'h1F7F);
      end
      send_key(1'b0, 9'h02D);
      step(2);
      send_key(1'b1, 9'h074);        // arrow without E0 prefix still matches
      step(2);
      o = outs();
      checks++;
      if (o !== 13'h1DFF) begin
         failures++;
         $display("FAIL key_right_noext: got %h expected %h", o, 13'h1DFF);
      end
      send_key(1'b0, 9'h074);
      step(2);
   endtask

   task automatic test_rotate();
      logic [12:0] o;
      bus.I_ROTATE = 1'b1;
      send_key(1'b1, 9'h16B);
      step(2);
      o = outs();
      checks++;
      if (o !== 13'h0FFF) begin
         failures++;
         $display("FAIL rot_left_to_up: got %h expected %h", o, 13'h0FFF);
      end
      bus.I_ROTATE = 1'b0;
      step(1);
      o = outs();
      checks++;
      if (o !== 13'h1BFF) begin
         failures++;
         $display("FAIL norot_left: got %h expected %h", o, 13'h1BFF);
      end
      send_key(1'b0, 9'h16B);
      step(2);
      bus.I_ROTATE = 1'b1;
      bus.I_JOY1[3] = 1'b1;          // joy up -> right on both players
      step(1);
      o = outs();
      checks++;
      if (o !== 13'h1DEF) begin
         failures++;
         $display("FAIL rot_joy_up_to_right: got %h expected %h", o, 13'h1DEF);
      end
      bus.I_ROTATE = 1'b0;
      step(1);
      o = outs();
      checks++;
      if (o !== 13'h0F7F) begin
         failures++;
         $display("FAIL norot_joy_up: got %h expected %h", o, 13'h0F7F);
      end
      bus.I_JOY1[3] = 1'b0;
      step(1);
   endtask

   task automatic test_joy_merge();
      logic [12:0] o;
      bus.I_JOY0[0] = 1'b1;
      bus.I_JOY1[4] = 1'b1;
      step(1);
      o = outs();
      checks++;
      if (o !== 13'h1CE7) begin
         failures++;
         $display("FAIL joy_or_merge: got %h expected %h", o, 13'h1CE7);
      end
      bus.I_JOY0[0] = 1'b0;
      bus.I_JOY1[4] = 1'b0;
      send_key(1'b1, 9'h06B);
      bus.I_JOY0[1] = 1'b1;
      step(2);
      send_key(1'b0, 9'h06B);
      step(2);
      o = outs();
      checks++;
      if (o !== 13'h1BDF) begin
         failures++;
         $display("FAIL key_joy_or_hold: got %h expected %h", o, 13'h1BDF);
      end
      bus.I_JOY0[1] = 1'b0;
      step(1);
      o = outs();
      checks++;
      if (o !== 13'h1FFF) begin
         failures++;
         $display("FAIL key_joy_release: got %h expected %h", o, 13'h1FFF);
      end
   endtask

   task automatic test_coin();
      int lows, falls;
      bus.I_JOY0[7] = 1'b1;
      measure_coin(100, lows, falls);
      checks++;
      if (lows !== COIN_CYCLES || falls !== 1) begin
         failures++;
         $display("FAIL coin_held: low=%0d pulses=%0d expected low=%0d pulses=1",
                  lows, falls, COIN_CYCLES);
      end
      bus.I_JOY0[7] = 1'b0;
      step(3);
      bus.I_JOY0[7] = 1'b1;
      measure_coin(40, lows, falls);
      checks++;
      if (lows !== COIN_CYCLES || falls !== 1) begin
         failures++;
         $display("FAIL coin_repress: low=%0d pulses=%0d expected low=%0d pulses=1",
                  lows, falls, COIN_CYCLES);
      end
      bus.I_JOY0[7] = 1'b0;
      step(3);
      send_key(1'b1, 9'h036);
      measure_coin(40, lows, falls);
      checks++;
      if (lows !== COIN_CYCLES || falls !== 1) begin
         failures++;
         $display("FAIL coin_key: low=%0d pulses=%0d expected low=%0d pulses=1",
                  lows, falls, COIN_CYCLES);
      end
      send_key(1'b0, 9'h036);
      step(3);
      // release and re-press during the pulse: no extension, no second pulse
      bus.I_JOY1[7] = 1'b1;
      step(4);
      bus.I_JOY1[7] = 1'b0;
      step(2);
      bus.I_JOY1[7] = 1'b1;
      measure_coin(40, lows, falls);
      checks++;
      if (lows !== COIN_CYCLES - 6 || falls !== 0) begin
         failures++;
         $display("FAIL coin_repress_in_pulse: low=%0d pulses=%0d expected low=%0d pulses=0",
                  lows, falls, COIN_CYCLES - 6);
      end
      bus.I_JOY1[7] = 1'b0;
      step(3);
      // release during the pulse: WAIT_REL leaves one cycle after entry
      bus.I_JOY0[7] = 1'b1;
      step(4);
      bus.I_JOY0[7] = 1'b0;
      step(COIN_CYCLES - 3);         // first cycle of WAIT_REL
      checks++;
      if (bus.O_C1 !== 1'b1) begin
         failures++;
         $display("FAIL coin_pulse_end: got %b expected 1", bus.O_C1);
      end
      step(1);                       // back in IDLE
      bus.I_JOY0[7] = 1'b1;
      step(1);
      checks++;
      if (bus.O_C1 !== 1'b0) begin
         failures++;
         $display("FAIL coin_wait_rel_exit: got %b expected 0", bus.O_C1);
      end
      bus.I_JOY0[7] = 1'b0;
      step(COIN_CYCLES + 3);
   endtask

   task automatic test_reset_mid_pulse();
      logic [12:0] o;
      int lows, falls;
      bus.I_JOY0[7] = 1'b1;
      step(6);                       // counter now at 5
      checks++;
      if (bus.O_C1 !== 1'b0) begin
         failures++;
         $display("FAIL coin_mid_pulse: got %b expected 0", bus.O_C1);
      end
      rst_n = 1'b0;
      #1;
      o = outs();
      checks++;
      if (o !== 13'h1FFF) begin
         failures++;
         $display("FAIL reset_abort_pulse: got %h expected %h", o, 13'h1FFF);
      end
      tog = 1'b0;
      bus.I_PS2_KEY = '0;
      step(2);
      rst_n = 1'b1;
      measure_coin(40, lows, falls);
      checks++;
      if (lows !== COIN_CYCLES || falls !== 1) begin
         failures++;
         $display("FAIL coin_after_reset: low=%0d pulses=%0d expected low=%0d pulses=1",
                  lows, falls, COIN_CYCLES);
      end
      bus.I_JOY0[7] = 1'b0;
      step(3);
   endtask

   task automatic test_autocoin();
      logic [12:0] o;
      int lows, falls;
      int exp_lows;
`ifdef DKONG_AUTOCOIN_EN
      exp_lows = COIN_CYCLES;
`else
      exp_lows = 0;
`endif
      send_key(1'b1, 9'h016);
      measure_coin(40, lows, falls);
      checks++;
      if (lows !== exp_lows) begin
         failures++;
         $display("FAIL autocoin_pulse: low=%0d expected %0d", lows, exp_lows);
      end
      checks++;
      if (bus.O_S1 !== 1'b0) begin
         failures++;
         $display("FAIL start1_key: got %b expected 0", bus.O_S1);
      end
      send_key(1'b0, 9'h016);
      step(3);
      o = outs();
      checks++;
      if (o !== 13'h1FFF) begin
         failures++;
         $display("FAIL start1_release: got %h expected %h", o, 13'h1FFF);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_key_event();
      test_rotate();
      test_joy_merge();
      test_coin();
      test_reset_mid_pulse();
      test_autocoin();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
